triangle_setup: RTL
===================

Name: triangle_setup

Overview:
- Downstream consumer of the triangle projection stage. Takes one projected triangle in screen space, Q16.16 per vertex {inv_w, z, y, x}.
- Computes the signed doubled area (edge function), classifies the triangle, and computes an integer pixel bounding box clamped to the framebuffer.
- Surviving triangles go to the rasterizer over a valid/ready handshake.
- Culled triangles are reported with a done pulse plus a status code, so the triangle sequencer can issue the next triangle.

Parameters:
- COORD_WIDTH, 32, fixed-point word width; COORD_WIDTH/2 fractional bits.
- FB_WIDTH, 320, framebuffer width in pixels.
- FB_HEIGHT, 180, framebuffer height in pixels.
- CULL_BACKFACE, 1, 1 = discard triangles with negative area.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous active-high reset
- tri_verts_in  input  signed [2:0][3:0][COORD_WIDTH-1:0]  projected vertices, each {inv_w, z, y, x}
- tri_valid_in  input  1  projected triangle is valid
- tri_done_in  input  1  projection finished (valid or discarded)
- in_ready  output  1  high only in IDLE; sequencer must not start a projection unless high
- out_verts  output  signed [2:0][3:0][COORD_WIDTH-1:0]  registered copy of accepted vertices
- out_area  output  signed [2*COORD_WIDTH-1:0]  doubled signed area, Q(2W-2F).(2F)
- out_min_x, out_max_x  output  $clog2(FB_WIDTH)  clamped integer bbox x
- out_min_y, out_max_y  output  $clog2(FB_HEIGHT)  clamped integer bbox y
- out_valid  output  1  setup result available
- out_ready  input  1  rasterizer accepts result
- status  output  2  0 ok, 1 backface, 2 degenerate, 3 offscreen
- done  output  1  one-cycle pulse per accepted triangle

Behaviour:
- Reset values: all outputs 0 except in_ready = 1; state IDLE; edge-detect register 0.
- Reset in any state aborts the in-flight triangle with no done pulse.
- Accept condition: acc = tri_valid_in && tri_done_in.
  - Upstream may hold acc for up to 2 consecutive cycles per triangle; the block accepts only on the rising edge of acc (acc && !acc_q).
  - tri_done_in without tri_valid_in is ignored.
  - Accept edges outside IDLE are ignored and dropped.
- FSM states: IDLE, DIFF, MUL, CLASSIFY, OUTPUT, DONE.
- IDLE: on accept, register tri_verts_in, go to DIFF.
- DIFF: register e1x = x1-x0, e1y = y1-y0, e2x = x2-x0, e2y = y2-y0 (W-bit, wrap not checked). Register floor(min) and ceil(max) of x and y:
  - floor = arithmetic shift right by F.
  - ceil = floor + 1 when the fractional bits are nonzero.
- MUL: register p0 = e1x*e2y and p1 = e2x*e1y, full 2W signed.
- CLASSIFY: area = p0 - p1, then resolve in priority order:
  - area == 0 -> status 2.
  - area < 0 && CULL_BACKFACE -> status 1.
  - max_x < 0, min_x > FB_WIDTH-1, max_y < 0 or min_y > FB_HEIGHT-1 -> status 3.
  - Otherwise clamp min to >= 0 and max to <= FB_*-1, load outputs, status 0, go to OUTPUT.
  - Culled cases go directly to DONE.
- OUTPUT: out_valid = 1. All out_* are stable while out_valid && !out_ready. On out_valid && out_ready, out_valid drops next cycle and the FSM goes to DONE.
- DONE: done = 1 for exactly one cycle with status valid, then IDLE. in_ready rises the cycle after done.
- Latency: accept edge at cycle N gives out_valid high in cycle N+4. A culled triangle gives done in cycle N+4.
- Throughput: at most one triangle in flight; no input buffering.
- out_area, out_verts and bbox keep their last values after handshake until the next load.

Test Plan:
1. Front-facing: verts (10,10), (20,10), (10,30), out_ready held low 3 cycles -> out_valid at N+4, out_area = 200<<32, bbox x 10..20, y 10..30, outputs stable for 3 cycles, done status 0 one cycle after handshake.
2. Same triangle with v1/v2 swapped, CULL_BACKFACE = 1 -> no out_valid, done at N+4 with status 1. With CULL_BACKFACE = 0 -> out_valid, area = -(200<<32).
3. Collinear (0,0), (5,5), (10,10) -> status 2, no out_valid. Fractional (10.5,2.25), (20.25,2.25), (10.5,9.75) -> bbox x 10..21, y 2..10.
4. Clamping: x span -5.5..400.25, y span -3..200 -> bbox 0..319, 0..179. All x >= 330.0 -> status 3.
5. Handshake edge cases:
   - acc held 2 cycles -> exactly one accept and one done.
   - acc pulse during OUTPUT -> ignored, in_ready = 0.
   - tri_done_in without tri_valid_in -> no response.
6. rst_in asserted in MUL and again in OUTPUT -> next cycle IDLE, in_ready = 1, out_valid = 0, done = 0. A fresh triangle afterwards completes normally.

Source files
------------

// File: rtl/triangle_setup.sv
// Triangle setup: signed doubled area, face/degenerate/offscreen classification
// and a framebuffer-clamped integer bounding box for one projected triangle.
module triangle_setup #(
  parameter int COORD_WIDTH   = 32,
  parameter int FB_WIDTH      = 320,
  parameter int FB_HEIGHT     = 180,
  parameter int CULL_BACKFACE = 1
) (
  input  logic                                      clk_in,
  input  logic                                      rst_in,
  input  logic signed [2:0][3:0][COORD_WIDTH-1:0]   tri_verts_in,
  input  logic                                      tri_valid_in,
  input  logic                                      tri_done_in,
  output logic                                      in_ready,
  output logic signed [2:0][3:0][COORD_WIDTH-1:0]   out_verts,
  output logic signed [2*COORD_WIDTH-1:0]           out_area,
  output logic [$clog2(FB_WIDTH)-1:0]               out_min_x,
  output logic [$clog2(FB_WIDTH)-1:0]               out_max_x,
  output logic [$clog2(FB_HEIGHT)-1:0]              out_min_y,
  output logic [$clog2(FB_HEIGHT)-1:0]              out_max_y,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [1:0]                                status,
  output logic                                      done
);

  localparam int W  = COORD_WIDTH;
  localparam int F  = COORD_WIDTH / 2;
  localparam int XW = $clog2(FB_WIDTH);
  localparam int YW = $clog2(FB_HEIGHT);
  localparam logic signed [W-1:0] X_LAST = W'(FB_WIDTH - 1);
  localparam logic signed [W-1:0] Y_LAST = W'(FB_HEIGHT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_DIFF, S_MUL, S_CLASSIFY, S_OUTPUT, S_DONE
  } state_t;

  state_t state_q, state_d;
  logic acc_q, acc_d, acc;
  logic signed [2:0][3:0][W-1:0] verts_q, verts_d;
  logic signed [W-1:0] e1x_q, e1x_d, e1y_q, e1y_d, e2x_q, e2x_d, e2y_q, e2y_d;
  logic signed [W-1:0] bmin_x_q, bmin_x_d, bmax_x_q, bmax_x_d;
  logic signed [W-1:0] bmin_y_q, bmin_y_d, bmax_y_q, bmax_y_d;
  logic signed [2*W-1:0] p0_q, p0_d, p1_q, p1_d, area;
  logic signed [2:0][3:0][W-1:0] out_verts_q, out_verts_d;
  logic signed [2*W-1:0] out_area_q, out_area_d;
  logic [XW-1:0] out_min_x_q, out_min_x_d, out_max_x_q, out_max_x_d;
  logic [YW-1:0] out_min_y_q, out_min_y_d, out_max_y_q, out_max_y_d;
  logic [1:0] status_q, status_d;
  logic signed [W-1:0] x0, x1, x2, y0, y1, y2;

  function automatic logic signed [W-1:0] floor_fx(input logic signed [W-1:0] v);
    return v >>> F;
  endfunction

  function automatic logic signed [W-1:0] ceil_fx(input logic signed [W-1:0] v);
    return floor_fx(v) + $signed({{(W-1){1'b0}}, |v[F-1:0]});
  endfunction

  function automatic logic signed [W-1:0] min3(input logic signed [W-1:0] a, b, c);
    logic signed [W-1:0] m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic logic signed [W-1:0] max3(input logic signed [W-1:0] a, b, c);
    logic signed [W-1:0] m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

  assign acc  = tri_valid_in && tri_done_in;
  assign area = p0_q - p1_q;
  assign x0 = $signed(verts_q[0][0]);
  assign x1 = $signed(verts_q[1][0]);
  assign x2 = $signed(verts_q[2][0]);
  assign y0 = $signed(verts_q[0][1]);
  assign y1 = $signed(verts_q[1][1]);
  assign y2 = $signed(verts_q[2][1]);

  always_comb begin
    state_d     = state_q;
    acc_d       = acc;
    verts_d     = verts_q;
    e1x_d       = e1x_q;
    e1y_d       = e1y_q;
    e2x_d       = e2x_q;
    e2y_d       = e2y_q;
    bmin_x_d    = bmin_x_q;
    bmax_x_d    = bmax_x_q;
    bmin_y_d    = bmin_y_q;
    bmax_y_d    = bmax_y_q;
    p0_d        = p0_q;
    p1_d        = p1_q;
    out_verts_d = out_verts_q;
    out_area_d  = out_area_q;
    out_min_x_d = out_min_x_q;
    out_max_x_d = out_max_x_q;
    out_min_y_d = out_min_y_q;
    out_max_y_d = out_max_y_q;
    status_d    = status_q;

    case (state_q)
      S_IDLE: begin
        // Upstream may hold acc for two cycles; only its rising edge starts a triangle.
        if (acc && !acc_q) begin
          verts_d = tri_verts_in;
          state_d = S_DIFF;
        end
      end
      S_DIFF: begin
        e1x_d    = x1 - x0;
        e1y_d    = y1 - y0;
        e2x_d    = x2 - x0;
        e2y_d    = y2 - y0;
        bmin_x_d = floor_fx(min3(x0, x1, x2));
        bmax_x_d = ceil_fx(max3(x0, x1, x2));
        bmin_y_d = floor_fx(min3(y0, y1, y2));
        bmax_y_d = ceil_fx(max3(y0, y1, y2));
        state_d  = S_MUL;
      end
      S_MUL: begin
        p0_d    = (2*W)'(e1x_q) * (2*W)'(e2y_q);
        p1_d    = (2*W)'(e2x_q) * (2*W)'(e1y_q);
        state_d = S_CLASSIFY;
      end
      S_CLASSIFY: begin
        if (area == '0) begin
          status_d = 2'd2;
          state_d  = S_DONE;
        end else if (area[2*W-1] && (CULL_BACKFACE != 0)) begin
          status_d = 2'd1;
          state_d  = S_DONE;
        end else if (bmax_x_q[W-1] || (bmin_x_q > X_LAST) ||
                     bmax_y_q[W-1] || (bmin_y_q > Y_LAST)) begin
          status_d = 2'd3;
          state_d  = S_DONE;
        end else begin
          status_d    = 2'd0;
          out_verts_d = verts_q;
          out_area_d  = area;
          out_min_x_d = bmin_x_q[W-1] ? '0 : bmin_x_q[XW-1:0];
          out_max_x_d = (bmax_x_q > X_LAST) ? X_LAST[XW-1:0] : bmax_x_q[XW-1:0];
          out_min_y_d = bmin_y_q[W-1] ? '0 : bmin_y_q[YW-1:0];
          out_max_y_d = (bmax_y_q > Y_LAST) ? Y_LAST[YW-1:0] : bmax_y_q[YW-1:0];
          state_d     = S_OUTPUT;
        end
      end
      S_OUTPUT: begin
        if (out_ready) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= S_IDLE;
      acc_q       <= 1'b0;
      verts_q     <= '0;
      e1x_q       <= '0;
      e1y_q       <= '0;
      e2x_q       <= '0;
      e2y_q       <= '0;
      bmin_x_q    <= '0;
      bmax_x_q    <= '0;
      bmin_y_q    <= '0;
      bmax_y_q    <= '0;
      p0_q        <= '0;
      p1_q        <= '0;
      out_verts_q <= '0;
      out_area_q  <= '0;
      out_min_x_q <= '0;
      out_max_x_q <= '0;
      out_min_y_q <= '0;
      out_max_y_q <= '0;
      status_q    <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      verts_q     <= verts_d;
      e1x_q       <= e1x_d;
      e1y_q       <= e1y_d;
      e2x_q       <= e2x_d;
      e2y_q       <= e2y_d;
      bmin_x_q    <= bmin_x_d;
      bmax_x_q    <= bmax_x_d;
      bmin_y_q    <= bmin_y_d;
      bmax_y_q    <= bmax_y_d;
      p0_q        <= p0_d;
      p1_q        <= p1_d;
      out_verts_q <= out_verts_d;
      out_area_q  <= out_area_d;
      out_min_x_q <= out_min_x_d;
      out_max_x_q <= out_max_x_d;
      out_min_y_q <= out_min_y_d;
      out_max_y_q <= out_max_y_d;
      status_q    <= status_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_OUTPUT);
  assign done      = (state_q == S_DONE);
  assign out_verts = out_verts_q;
  assign out_area  = out_area_q;
  assign out_min_x = out_min_x_q;
  assign out_max_x = out_max_x_q;
  assign out_min_y = out_min_y_q;
  assign out_max_y = out_max_y_q;
  assign status    = status_q;

endmodule
